sevenseg_scan_reader: RTL and testbench

Inverse of the team's hex-to-seven-segment decoder. It watches a multiplexed, active-low seven-segment display bus (segment lines plus one-hot active-low digit selects) and recovers the hex digit shown on each position. Each position's pattern is debounced, decoded back to a 4-bit hex value, and collected per digit. A packed value is published once every digit has been seen, with a one-cycle frame strobe. Used by self-check logic and board-level loopback tests of the display drivers.

---
 rtl/sevenseg_scan_reader.sv | 161 ++++++++++++++++
 tb/tb_sevenseg_scan_reader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_reader.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus.
// Each position is debounced, decoded and collected into a packed frame.
module sevenseg_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel_n,
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic [NUM_DIGITS-1:0]   err_out,
    output logic                    frame_valid,
    output logic                    frame_err
);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    localparam logic [7:0]            STABLE_C = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ZERO_C   = {NUM_DIGITS{1'b0}};
    localparam logic [NUM_DIGITS-1:0] ONE_C    = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] ALL_C    = {NUM_DIGITS{1'b1}};

    // Returns {err, blank, nibble} for one active-low segment pattern.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'b1000000: decode_seg = {2'b00, 4'h0};
            7'b1111001: decode_seg = {2'b00, 4'h1};
            7'b0100100: decode_seg = {2'b00, 4'h2};
            7'b0110000: decode_seg = {2'b00, 4'h3};
            7'b0011001: decode_seg = {2'b00, 4'h4};
            7'b0010010: decode_seg = {2'b00, 4'h5};
            7'b0000010: decode_seg = {2'b00, 4'h6};
            7'b1111000: decode_seg = {2'b00, 4'h7};
            7'b0000000: decode_seg = {2'b00, 4'h8};
            7'b0010000: decode_seg = {2'b00, 4'h9};
            7'b0001000: decode_seg = {2'b00, 4'hA};
            7'b0000011: decode_seg = {2'b00, 4'hB};
            7'b1000110: decode_seg = {2'b00, 4'hC};
            7'b0100001: decode_seg = {2'b00, 4'hD};
            7'b0000110: decode_seg = {2'b00, 4'hE};
            7'b0001110: decode_seg = {2'b00, 4'hF};
            7'b1111111: decode_seg = {2'b01, 4'h0};
            default:    decode_seg = {2'b10, 4'h0};
        endcase
    endfunction

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        is_onehot = (v != ZERO_C) && ((v & (v - ONE_C)) == ZERO_C);
    endfunction

    logic [6:0]              seg_r;
    logic [NUM_DIGITS-1:0]   sel_n_r;
    logic [7:0]              cnt_r, cnt_s;
    state_t                  state_r, state_s;
    logic [NUM_DIGITS-1:0]   sel_hot_s;
    logic                    sel_ok_s, prev_ok_s, same_s, commit_s, frame_done_s;
    logic [5:0]              dec_s;
    logic [4*NUM_DIGITS-1:0] sh_val_r, sh_val_s;
    logic [NUM_DIGITS-1:0]   sh_blank_r, sh_blank_s, sh_err_r, sh_err_s;
    logic [NUM_DIGITS-1:0]   seen_r, seen_s;

    assign sel_hot_s = ~dig_sel_n;
    assign sel_ok_s  = is_onehot(sel_hot_s);
    assign prev_ok_s = is_onehot(~sel_n_r);
    assign same_s    = (seg_in == seg_r) && (dig_sel_n == sel_n_r);
    assign commit_s  = (state_s == ST_COMMIT);
    assign dec_s     = decode_seg(seg_in);

    // Stability counter and debounce state; the incoming sample counts this edge.
    always_comb begin
        cnt_s   = cnt_r;
        state_s = state_r;
        if (!sel_ok_s) begin
            cnt_s   = 8'd0;
            state_s = ST_WAIT;
        end else if (!prev_ok_s || !same_s) begin
            cnt_s   = 8'd1;
            state_s = ST_WAIT;
        end else begin
            if (cnt_r < STABLE_C) begin
                cnt_s = cnt_r + 8'd1;
            end else begin
                cnt_s = cnt_r;
            end
            case (state_r)
                ST_WAIT:   state_s = (cnt_s == STABLE_C) ? ST_COMMIT : ST_WAIT;
                ST_COMMIT: state_s = ST_HELD;
                ST_HELD:   state_s = ST_HELD;
                default:   state_s = ST_WAIT;
            endcase
        end
    end

    // Shadow slot update and frame completion detect on a commit edge.
    always_comb begin
        sh_val_s   = sh_val_r;
        sh_blank_s = sh_blank_r;
        sh_err_s   = sh_err_r;
        seen_s     = seen_r;
        if (commit_s) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel_hot_s[i]) begin
                    sh_val_s[4*i +: 4] = dec_s[3:0];
                    sh_blank_s[i]      = dec_s[4];
                    sh_err_s[i]        = dec_s[5];
                end else begin
                    sh_val_s[4*i +: 4] = sh_val_r[4*i +: 4];
                end
            end
            seen_s = seen_r | sel_hot_s;
        end else begin
            seen_s = seen_r;
        end
        frame_done_s = commit_s && (seen_s == ALL_C);
    end

    // Sample, debounce, shadow and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_r       <= 7'd0;
            sel_n_r     <= ZERO_C;
            cnt_r       <= 8'd0;
            state_r     <= ST_WAIT;
            sh_val_r    <= {(4*NUM_DIGITS){1'b0}};
            sh_blank_r  <= ZERO_C;
            sh_err_r    <= ZERO_C;
            seen_r      <= ZERO_C;
            value_out   <= {(4*NUM_DIGITS){1'b0}};
            blank_out   <= ZERO_C;
            err_out     <= ZERO_C;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            seg_r      <= seg_in;
            sel_n_r    <= dig_sel_n;
            cnt_r      <= cnt_s;
            state_r    <= state_s;
            sh_val_r   <= sh_val_s;
            sh_blank_r <= sh_blank_s;
            sh_err_r   <= sh_err_s;
            if (frame_done_s) begin
                seen_r      <= ZERO_C;
                value_out   <= sh_val_s;
                blank_out   <= sh_blank_s;
                err_out     <= sh_err_s;
                frame_valid <= 1'b1;
                frame_err   <= |sh_err_s;
            end else begin
                seen_r      <= seen_s;
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_reader.sv
// Scoreboard bench for sevenseg_scan_reader: expected frames are queued as
// the scans are driven and compared when frame_valid pulses.
module tb_sevenseg_scan_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel_n;
    logic [15:0] value_out;
    logic [3:0]  blank_out, err_out;
    logic        frame_valid, frame_err;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  blank;
        logic [3:0]  err;
        logic        ferr;
        int          edge_n;
    } frame_t;

    frame_t      exp_q[$];
    frame_t      mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          edge_cnt = 0;
    logic [15:0] last_val = 16'h0;
    logic [3:0]  last_blank = 4'h0, last_err = 4'h0;
    logic        last_ferr = 1'b0;

    sevenseg_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel_n(dig_sel_n),
        .value_out(value_out), .blank_out(blank_out), .err_out(err_out),
        .frame_valid(frame_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] h);
        case (h)
            4'h0: enc = 7'b1000000;  4'h1: enc = 7'b1111001;
            4'h2: enc = 7'b0100100;  4'h3: enc = 7'b0110000;
            4'h4: enc = 7'b0011001;  4'h5: enc = 7'b0010010;
            4'h6: enc = 7'b0000010;  4'h7: enc = 7'b1111000;
            4'h8: enc = 7'b0000000;  4'h9: enc = 7'b0010000;
            4'hA: enc = 7'b0001000;  4'hB: enc = 7'b0000011;
            4'hC: enc = 7'b1000110;  4'hD: enc = 7'b0100001;
            4'hE: enc = 7'b0000110;  default: enc = 7'b0001110;
        endcase
    endfunction

    task automatic tick(input logic [6:0] seg, input logic [3:0] seln, input int n);
        repeat (n) begin
            seg_in    = seg;
            dig_sel_n = seln;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dwell(input int pos, input logic [6:0] seg, input int n);
        tick(seg, ~(4'b0001 << pos), n);
    endtask

    task automatic gap(input int n);
        tick(7'h7f, 4'b1111, n);
    endtask

    task automatic push_exp(input logic [15:0] v, input logic [3:0] b, input logic [3:0] e, input int edge_n);
        frame_t f;
        f.val = v; f.blank = b; f.err = e; f.ferr = |e; f.edge_n = edge_n;
        exp_q.push_back(f);
        last_val = v; last_blank = b; last_err = e; last_ferr = |e;
    endtask

    task automatic check_hold(input string tag);
        check_val({tag, "_value"}, value_out, last_val);
        check_val({tag, "_blank"}, blank_out, last_blank);
        check_val({tag, "_err"}, err_out, last_err);
        check_val({tag, "_ferr"}, frame_err, last_ferr);
        check_val({tag, "_fvalid"}, frame_valid, 1'b0);
    endtask

    // Frame monitor: every frame_valid pulse must match the head of the queue.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_frame", value_out, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("frame_value", value_out, mon_e.val);
                check_val("frame_blank", blank_out, mon_e.blank);
                check_val("frame_err_bits", err_out, mon_e.err);
                check_val("frame_err", frame_err, mon_e.ferr);
                check_val("frame_edge", edge_cnt, mon_e.edge_n);
            end
        end
    end

    initial begin
        int          ord[4];
        logic [3:0]  dg[4];
        logic [15:0] rv;
        int          j, tmp;

        // Reset with random bus activity
        rst_n = 1'b0;
        repeat (3) tick(7'($urandom), 4'($urandom), 1);
        check_hold("reset");
        rst_n = 1'b1;
        gap(10);
        check_hold("idle");

        // Normal frame 0..3 = 6, A, 1, F
        dwell(0, 7'b0000010, 8);
        dwell(1, 7'b0001000, 8);
        dwell(2, 7'b1111001, 8);
        push_exp(16'hF1A6, 4'b0000, 4'b0000, edge_cnt + 4);
        dwell(3, 7'b0001110, 8);
        gap(3);
        check_hold("normal");

        // Debounce: position 1 shows 2 briefly then settles on 3
        dwell(0, enc(4'h5), 6);
        dwell(2, enc(4'h7), 6);
        dwell(3, enc(4'h9), 6);
        push_exp(16'h9735, 4'b0000, 4'b0000, edge_cnt + 7);
        dwell(1, 7'b0100100, 3);
        dwell(1, 7'b0110000, 8);
        gap(3);
        check_hold("debounce");

        // One-cycle deselect inside the last dwell restarts the count
        dwell(0, enc(4'h0), 5);
        dwell(1, enc(4'h8), 5);
        dwell(2, enc(4'hB), 5);
        push_exp(16'hCB80, 4'b0000, 4'b0000, edge_cnt + 7);
        dwell(3, enc(4'hC), 2);
        tick(enc(4'hC), 4'b1111, 1);
        dwell(3, enc(4'hC), 6);
        gap(3);
        check_hold("glitch");

        // Blank and unrecognised patterns
        dwell(0, enc(4'h4), 5);
        dwell(1, enc(4'hD), 5);
        dwell(2, 7'b1111111, 5);
        push_exp(16'h00D4, 4'b0100, 4'b1000, edge_cnt + 4);
        dwell(3, 7'b0101010, 5);
        gap(3);
        check_hold("blank_err");

        // Two selects active: no commit; then scan order 3,1,0,2
        tick(enc(4'h8), 4'b1100, 10);
        dwell(3, enc(4'hE), 6);
        dwell(1, enc(4'h2), 6);
        dwell(0, enc(4'h7), 6);
        push_exp(16'hE927, 4'b0000, 4'b0000, edge_cnt + 4);
        dwell(2, enc(4'h9), 6);
        gap(3);
        check_hold("order");

        // Reset mid-frame discards positions 0 and 1
        dwell(0, enc(4'h1), 6);
        dwell(1, enc(4'h2), 6);
        rst_n = 1'b0;
        tick(enc(4'h2), 4'b1101, 1);
        rst_n = 1'b1;
        last_val = 16'h0; last_blank = 4'h0; last_err = 4'h0; last_ferr = 1'b0;
        check_hold("mid_reset");
        dwell(2, enc(4'h3), 6);
        dwell(3, enc(4'h4), 6);
        gap(5);
        check_hold("partial");
        dwell(0, enc(4'h5), 6);
        push_exp(16'h4365, 4'b0000, 4'b0000, edge_cnt + 4);
        dwell(1, enc(4'h6), 6);
        gap(3);
        check_hold("rescan");

        // Random digits in random scan order with random dwell lengths
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 4; i++) begin
                dg[i]  = 4'($urandom_range(0, 15));
                ord[i] = i;
            end
            for (int i = 3; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
            end
            rv = {dg[3], dg[2], dg[1], dg[0]};
            gap(1);
            for (int i = 0; i < 3; i++) dwell(ord[i], enc(dg[ord[i]]), int'($urandom_range(4, 9)));
            push_exp(rv, 4'b0000, 4'b0000, edge_cnt + 4);
            dwell(ord[3], enc(dg[ord[3]]), int'($urandom_range(4, 9)));
        end
        gap(5);
        check_hold("random");

        check_val("pending_frames", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
